// File: rtl/cp0_exception_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, FSM encodings
// and the Status/Cause field positions used by the controller and regfile.
package cp0_defs;

  // CP0 register numbers
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Exception sequencer states
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_ENTER  = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  // Status / Cause field positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;

endpackage

// File: rtl/cp0_exception_ctrl_if.sv
// Pipeline-to-CP0 signal bundle. The pipeline side (master) drives the
// Mem/Wr/ID stage request fields; the CP0 side (slave) drives the read data,
// flush/redirect controls and status observation outputs.
//
// Handshake semantics: there is no valid/ready back-pressure. mem_valid
// qualifies mem_exc/mem_eret (a bubble never raises an event), wr_cp0_we
// qualifies the mtc0 fields, and every CP0 output is valid in the same cycle
// it is driven; the pipeline must obey flush/pc_redirect unconditionally.
interface cp0_exception_ctrl_if #(
  parameter int IRQ_W = 6
);
  logic [IRQ_W-1:0] irq;
  logic             mem_valid;
  logic [31:0]      mem_pc;
  logic             mem_exc;
  logic [4:0]       mem_exccode;
  logic             mem_eret;
  logic             wr_cp0_we;
  logic [4:0]       wr_cp0_rd;
  logic [31:0]      wr_cp0_wdata;
  logic [4:0]       id_cp0_rd;
  logic [31:0]      id_cp0_rdata;
  logic             flush;
  logic             pc_redirect;
  logic [31:0]      redirect_pc;
  logic             exl;
  logic [1:0]       state_dbg;

  modport master (
    output irq, mem_valid, mem_pc, mem_exc, mem_exccode, mem_eret,
           wr_cp0_we, wr_cp0_rd, wr_cp0_wdata, id_cp0_rd,
    input  id_cp0_rdata, flush, pc_redirect, redirect_pc, exl, state_dbg
  );

  modport slave (
    input  irq, mem_valid, mem_pc, mem_exc, mem_exccode, mem_eret,
           wr_cp0_we, wr_cp0_rd, wr_cp0_wdata, id_cp0_rd,
    output id_cp0_rdata, flush, pc_redirect, redirect_pc, exl, state_dbg
  );
endinterface

// File: rtl/cp0_exception_ctrl_regfile.sv
// CP0 Status/Cause/EPC storage. Exception entry overrides mtc0 for EXL,
// ExcCode and EPC; ERET clears EXL after any same-edge mtc0 Status write.
// The mfc0 read port bypasses a same-cycle mtc0 (except for Cause).
module cp0_regfile
  import cp0_defs::*;
#(
  parameter int IRQ_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_W-1:0] irq,
  input  logic             wr_we,
  input  logic [4:0]       wr_rd,
  input  logic [31:0]      wr_wdata,
  input  logic [4:0]       rd_addr,
  output logic [31:0]      rd_data,
  input  logic             entry,
  input  logic [4:0]       entry_code,
  input  logic [31:0]      entry_pc,
  input  logic             eret,
  output logic             ie,
  output logic             exl,
  output logic [IRQ_W-1:0] im,
  output logic [IRQ_W-1:0] ip,
  output logic [31:0]      epc
);

  logic [4:0]  exccode_q;
  logic [31:0] status_word;
  logic [31:0] cause_word;
  logic [31:0] wr_status_word;
  logic        wr_status;
  logic        wr_epc;

  assign wr_status = wr_we && (wr_rd == CP0_STATUS);
  assign wr_epc    = wr_we && (wr_rd == CP0_EPC);

  // Register update: later assignments in this block take priority
  always_ff @(posedge clk) begin
    if (reset) begin
      ie        <= 1'b0;
      exl       <= 1'b0;
      im        <= '0;
      ip        <= '0;
      exccode_q <= '0;
      epc       <= '0;
    end else begin
      ip <= irq;
      if (wr_status) begin
        im  <= wr_wdata[STATUS_IM_LO +: IRQ_W];
        exl <= wr_wdata[STATUS_EXL];
        ie  <= wr_wdata[STATUS_IE];
      end
      if (wr_epc) begin
        epc <= wr_wdata;
      end
      if (entry) begin
        exl       <= 1'b1;
        exccode_q <= entry_code;
        epc       <= entry_pc;
      end else if (eret) begin
        exl <= 1'b0;
      end
    end
  end

  // Architectural register views; unimplemented bits read as zero
  always_comb begin
    status_word                             = '0;
    status_word[STATUS_IM_LO +: IRQ_W]      = im;
    status_word[STATUS_EXL]                 = exl;
    status_word[STATUS_IE]                  = ie;
    wr_status_word                          = '0;
    wr_status_word[STATUS_IM_LO +: IRQ_W]   = wr_wdata[STATUS_IM_LO +: IRQ_W];
    wr_status_word[STATUS_EXL]              = wr_wdata[STATUS_EXL];
    wr_status_word[STATUS_IE]               = wr_wdata[STATUS_IE];
    cause_word                              = '0;
    cause_word[CAUSE_IP_LO +: IRQ_W]        = ip;
    cause_word[CAUSE_EXC_LO +: 5]           = exccode_q;
  end

  // mfc0 read port with same-cycle mtc0 bypass
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CP0_STATUS: rd_data = (wr_status && (rd_addr == wr_rd)) ? wr_status_word : status_word;
      CP0_CAUSE:  rd_data = cause_word;
      CP0_EPC:    rd_data = (wr_epc && (rd_addr == wr_rd)) ? wr_wdata : epc;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 exception controller: arbitrates Mem-stage exceptions, interrupts and
// ERET, then spends one cycle flushing the pipeline and redirecting the PC.
module cp0_exception_ctrl
  import cp0_defs::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          IRQ_W        = 6
) (
  input logic                 clk,
  input logic                 reset,
  cp0_exception_ctrl_if.slave bus
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [31:0]      ret_target_q;
  logic             in_run;
  logic             int_req;
  logic             take_exc;
  logic             take_int;
  logic             take_eret;
  logic             entry;
  logic [4:0]       entry_code;
  logic [31:0]      eret_target;
  logic             ie;
  logic             exl;
  logic [IRQ_W-1:0] im;
  logic [IRQ_W-1:0] ip;
  logic [31:0]      epc;

  assign in_run  = (state_q == ST_RUN);
  assign int_req = ie && !exl && (|(ip & im)) && bus.mem_valid && !bus.mem_eret;

  // Priority: synchronous exception, then interrupt, then ERET
  assign take_exc   = in_run && bus.mem_exc && bus.mem_valid;
  assign take_int   = in_run && !take_exc && int_req;
  assign take_eret  = in_run && !take_exc && !take_int && bus.mem_eret && bus.mem_valid;
  assign entry      = take_exc || take_int;
  assign entry_code = take_exc ? bus.mem_exccode : EXC_INT;

  // An mtc0 EPC committing alongside ERET supplies the return target
  assign eret_target = (bus.wr_cp0_we && (bus.wr_cp0_rd == CP0_EPC)) ? bus.wr_cp0_wdata : epc;

  // Next-state selection; ENTER and RETURN always last exactly one cycle
  always_comb begin
    state_d = ST_RUN;
    if (entry) begin
      state_d = ST_ENTER;
    end else if (take_eret) begin
      state_d = ST_RETURN;
    end
  end

  // State and ERET target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      ret_target_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_eret) begin
        ret_target_q <= eret_target;
      end
    end
  end

  // Redirect outputs; suppressed while reset is held so no redirect escapes
  always_comb begin
    bus.flush       = 1'b0;
    bus.pc_redirect = 1'b0;
    bus.redirect_pc = '0;
    if (!reset) begin
      if (state_q == ST_ENTER) begin
        bus.flush       = 1'b1;
        bus.pc_redirect = 1'b1;
        bus.redirect_pc = HANDLER_ADDR;
      end else if (state_q == ST_RETURN) begin
        bus.flush       = 1'b1;
        bus.pc_redirect = 1'b1;
        bus.redirect_pc = ret_target_q;
      end
    end
  end

  assign bus.exl       = exl;
  assign bus.state_dbg = state_q;

  cp0_regfile #(
    .IRQ_W (IRQ_W)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .irq        (bus.irq),
    .wr_we      (bus.wr_cp0_we),
    .wr_rd      (bus.wr_cp0_rd),
    .wr_wdata   (bus.wr_cp0_wdata),
    .rd_addr    (bus.id_cp0_rd),
    .rd_data    (bus.id_cp0_rdata),
    .entry      (entry),
    .entry_code (entry_code),
    .entry_pc   (bus.mem_pc),
    .eret       (take_eret),
    .ie         (ie),
    .exl        (exl),
    .im         (im),
    .ip         (ip),
    .epc        (epc)
  );

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Bench for cp0_exception_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level architectural model.
module tb_cp0_exception_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cp0_exception_ctrl_if #(.IRQ_W(6)) bus ();

  cp0_exception_ctrl #(
    .HANDLER_ADDR (HANDLER),
    .IRQ_W        (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // pend: 0 = no redirect pending, 1 = redirect to handler, 2 = redirect to ERET target
  logic [5:0]  m_im;
  logic        m_ie;
  logic        m_exl;
  logic [5:0]  m_ip;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  int          m_pend;
  logic [31:0] m_target;

  function automatic logic [31:0] m_status();
    return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_ip) << 10) | (32'(m_code) << 2);
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [31:0] v;
    v = 32'h0;
    if (bus.id_cp0_rd == 5'd12) begin
      if (bus.wr_cp0_we && bus.wr_cp0_rd == 5'd12) v = bus.wr_cp0_wdata & 32'h0000_FC03;
      else v = m_status();
    end else if (bus.id_cp0_rd == 5'd13) begin
      v = m_cause();
    end else if (bus.id_cp0_rd == 5'd14) begin
      if (bus.wr_cp0_we && bus.wr_cp0_rd == 5'd14) v = bus.wr_cp0_wdata;
      else v = m_epc;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_im = '0; m_ie = 1'b0; m_exl = 1'b0; m_ip = '0;
    m_code = '0; m_epc = '0; m_pend = 0; m_target = '0;
  endtask

  // Advance the model across one rising edge using the current inputs
  task automatic model_step();
    logic        irq_pending;
    logic [31:0] old_epc;
    if (reset) begin
      model_reset();
    end else begin
      irq_pending = m_ie && !m_exl && ((m_ip & m_im) != 6'd0) && bus.mem_valid && !bus.mem_eret;
      old_epc = m_epc;
      if (bus.wr_cp0_we && bus.wr_cp0_rd == 5'd12) begin
        m_im  = bus.wr_cp0_wdata[15:10];
        m_exl = bus.wr_cp0_wdata[1];
        m_ie  = bus.wr_cp0_wdata[0];
      end
      if (bus.wr_cp0_we && bus.wr_cp0_rd == 5'd14) m_epc = bus.wr_cp0_wdata;
      if (m_pend != 0) begin
        m_pend = 0;
      end else if (bus.mem_exc && bus.mem_valid) begin
        m_epc = bus.mem_pc; m_code = bus.mem_exccode; m_exl = 1'b1; m_pend = 1;
      end else if (irq_pending) begin
        m_epc = bus.mem_pc; m_code = 5'd0; m_exl = 1'b1; m_pend = 1;
      end else if (bus.mem_eret && bus.mem_valid) begin
        m_target = (bus.wr_cp0_we && bus.wr_cp0_rd == 5'd14) ? bus.wr_cp0_wdata : old_epc;
        m_exl = 1'b0; m_pend = 2;
      end
      m_ip = bus.irq;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.mem_valid = 1'b0; bus.mem_pc = '0; bus.mem_exc = 1'b0;
    bus.mem_exccode = '0; bus.mem_eret = 1'b0; bus.wr_cp0_we = 1'b0;
    bus.wr_cp0_rd = '0; bus.wr_cp0_wdata = '0; bus.id_cp0_rd = '0;
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [31:0] data);
    bus.wr_cp0_we = 1'b1; bus.wr_cp0_rd = rd; bus.wr_cp0_wdata = data;
  endtask

  // Called just after a falling edge with inputs set: compare, step model, move to next falling edge
  task automatic tick();
    logic [31:0] exp_pc;
    #1;
    exp_pc = reset ? 32'h0 : (m_pend == 1) ? HANDLER : (m_pend == 2) ? m_target : 32'h0;
    check_val("state_dbg", 32'(bus.state_dbg), 32'(m_pend));
    check_val("flush", 32'(bus.flush), 32'((m_pend != 0) && !reset));
    check_val("pc_redirect", 32'(bus.pc_redirect), 32'((m_pend != 0) && !reset));
    check_val("redirect_pc", bus.redirect_pc, exp_pc);
    check_val("exl", 32'(bus.exl), 32'(m_exl));
    check_val("rdata", bus.id_cp0_rdata, exp_rdata());
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_check(input string tag, input logic [4:0] rd, input logic [31:0] exp);
    bus.id_cp0_rd = rd;
    #1;
    check_val(tag, bus.id_cp0_rdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] codes[3];
    logic [4:0] rds[4];
    checks = 0;
    failures = 0;
    codes[0] = 5'd8; codes[1] = 5'd10; codes[2] = 5'd12;
    reset = 1'b1;
    bus.irq = '0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    tick();
    reset = 1'b0;
    read_check("reset_status", 5'd12, 32'h0);
    read_check("reset_cause", 5'd13, 32'h0);
    read_check("reset_epc", 5'd14, 32'h0);
    tick();

    // Syscall entry
    bus.mem_valid = 1'b1; bus.mem_exc = 1'b1; bus.mem_exccode = 5'd8; bus.mem_pc = 32'h3010;
    tick();
    clear_inputs();
    #1;
    check_val("sys_flush", 32'(bus.flush), 32'h1);
    check_val("sys_redirect", bus.redirect_pc, 32'h4180);
    check_val("sys_exl", 32'(bus.exl), 32'h1);
    read_check("sys_epc", 5'd14, 32'h3010);
    read_check("sys_code", 5'd13, 32'h20);
    tick();

    // Interrupt taken after the IP latch
    mtc0(5'd12, 32'h0401);
    tick();
    clear_inputs();
    bus.irq = 6'h01;
    tick();
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h3020;
    tick();
    clear_inputs();
    #1;
    check_val("int_flush", 32'(bus.flush), 32'h1);
    check_val("int_redirect", bus.redirect_pc, 32'h4180);
    read_check("int_cause", 5'd13, 32'h0400);
    read_check("int_epc", 5'd14, 32'h3020);
    tick();

    // Interrupt masked by IE = 0
    mtc0(5'd12, 32'h0400);
    tick();
    clear_inputs();
    bus.mem_valid = 1'b1;
    tick();
    #1;
    check_val("ie0_no_flush", 32'(bus.flush), 32'h0);
    // Interrupt masked by EXL = 1
    clear_inputs();
    mtc0(5'd12, 32'h0403);
    tick();
    clear_inputs();
    bus.mem_valid = 1'b1;
    tick();
    #1;
    check_val("exl1_no_flush", 32'(bus.flush), 32'h0);

    // ERET with same-cycle mtc0 EPC
    clear_inputs();
    bus.irq = '0;
    tick();
    bus.mem_valid = 1'b1; bus.mem_eret = 1'b1;
    mtc0(5'd14, 32'h3100);
    tick();
    clear_inputs();
    #1;
    check_val("eret_redirect", bus.redirect_pc, 32'h3100);
    check_val("eret_exl", 32'(bus.exl), 32'h0);
    tick();

    // Exception beats a simultaneous interrupt; second exception in ENTER is ignored
    bus.irq = 6'h01;
    tick();
    bus.mem_valid = 1'b1; bus.mem_exc = 1'b1; bus.mem_exccode = 5'd12; bus.mem_pc = 32'h3040;
    tick();
    bus.mem_exccode = 5'd8; bus.mem_pc = 32'h3050;
    read_check("simul_code", 5'd13, 32'h0430);
    tick();
    clear_inputs();
    read_check("simul_epc", 5'd14, 32'h3040);
    check_val("simul_state", 32'(bus.state_dbg), 32'h0);
    bus.irq = '0;
    tick();

    // mfc0 bypass and unimplemented register
    mtc0(5'd12, 32'h0000_FC01);
    read_check("mfc0_bypass", 5'd12, 32'h0000_FC01);
    tick();
    clear_inputs();
    mtc0(5'd5, 32'hDEAD_BEEF);
    read_check("mfc0_rd5", 5'd5, 32'h0);
    tick();
    clear_inputs();

    // Reset during ENTER
    bus.mem_valid = 1'b1; bus.mem_exc = 1'b1; bus.mem_exccode = 5'd10; bus.mem_pc = 32'h3060;
    tick();
    clear_inputs();
    reset = 1'b1;
    #1;
    check_val("rst_mid_flush", 32'(bus.flush), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check_val("rst_mid_state", 32'(bus.state_dbg), 32'h0);
    check_val("rst_mid_redirect", 32'(bus.pc_redirect), 32'h0);
    read_check("rst_mid_status", 5'd12, 32'h0);
    read_check("rst_mid_epc", 5'd14, 32'h0);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rds[0] = 5'd12; rds[1] = 5'd13; rds[2] = 5'd14; rds[3] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) bus.irq = 6'($urandom_range(0, 63));
      bus.mem_valid    = ($urandom_range(0, 3) != 0);
      bus.mem_pc       = $urandom & 32'hFFFF_FFFC;
      bus.mem_exc      = ($urandom_range(0, 9) == 0);
      bus.mem_exccode  = codes[$urandom_range(0, 2)];
      bus.mem_eret     = ($urandom_range(0, 6) == 0);
      bus.wr_cp0_we    = ($urandom_range(0, 3) == 0);
      bus.wr_cp0_rd    = rds[$urandom_range(0, 3)];
      bus.wr_cp0_wdata = $urandom;
      bus.id_cp0_rd    = rds[$urandom_range(0, 3)];
      reset            = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_exception_ctrl.md
Name: cp0_exception_ctrl

Overview:
- Controls CP0 for the 5-stage MIPS pipeline: holds Status (12), Cause (13) and EPC (14).
- Arbitrates Mem-stage exceptions and external interrupts, and sequences exception entry and ERET return.
- Drives pipeline flush and PC redirect.
- Services mtc0 writes (Wr stage) and mfc0 reads (ID stage).

Parameters:
- HANDLER_ADDR, 32'h0000_4180, PC loaded on exception/interrupt entry.
- IRQ_W, 6, number of hardware interrupt lines (maps to IM/IP bits 15:10).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- irq  in  IRQ_W  level-sensitive interrupt requests.
- mem_valid  in  1  Mem stage holds a real (non-bubble) instruction.
- mem_pc  in  32  PC of the Mem-stage instruction.
- mem_exc  in  1  Mem-stage instruction raised an exception.
- mem_exccode  in  5  ExcCode for mem_exc (8 syscall, 10 RI, 12 Ov).
- mem_eret  in  1  Mem-stage instruction is ERET.
- wr_cp0_we  in  1  mtc0 commit in the Wr stage.
- wr_cp0_rd  in  5  mtc0 destination register number.
- wr_cp0_wdata  in  32  mtc0 data.
- id_cp0_rd  in  5  mfc0 source register number.
- id_cp0_rdata  out  32  mfc0 read data (combinational, with Wr bypass).
- flush  out  1  kill IF/ID/EX/Mem instructions this cycle.
- pc_redirect  out  1  load next PC from redirect_pc.
- redirect_pc  out  32  target: HANDLER_ADDR or EPC.
- exl  out  1  Status.EXL.
- state_dbg  out  2  current FSM state.

Behaviour:
- Reset: Status = 0, Cause = 0, EPC = 0, FSM = RUN. Outputs: flush = 0, pc_redirect = 0, redirect_pc = 0.
- Status: IM[15:10] and EXL[1] and IE[0] are writable; all other bits read 0.
- Cause: IP[15:10] and ExcCode[6:2] are visible. IP is loaded every cycle with the registered irq, so it lags irq by 1 cycle. mtc0 to Cause is ignored.
- EPC: full 32 bits, writable by mtc0.
- Interrupt pending: int_req = IE & ~EXL & |(IP & IM) & mem_valid & ~mem_eret.
- FSM has 3 states: RUN, ENTER, RETURN.
- RUN, mem_exc & mem_valid (highest priority):
  - next state ENTER; latch mem_pc into EPC; latch mem_exccode into Cause.ExcCode; set EXL.
- RUN, else int_req:
  - next state ENTER; latch mem_pc into EPC (the Mem instruction is re-executed); Cause.ExcCode = 0; set EXL.
- RUN, else mem_eret & mem_valid:
  - next state RETURN; clear EXL.
  - The redirect target is EPC. If wr_cp0_we & wr_cp0_rd == 14 in the same cycle, wr_cp0_wdata is used instead.
- ENTER (1 cycle): flush = 1, pc_redirect = 1, redirect_pc = HANDLER_ADDR; next state RUN.
- RETURN (1 cycle): flush = 1, pc_redirect = 1, redirect_pc = the latched ERET target; next state RUN.
  - The target is captured into an internal register on the RUN→RETURN transition.
- Latency: event is sampled in Mem at edge N; redirect/flush are asserted during cycle N+1.
- In ENTER/RETURN, the mem_exc, int_req and mem_eret inputs are ignored, since those instructions are being flushed.
- mtc0 is still applied in every state: the Wr instruction is older and commits.
- mtc0 and an exception/interrupt take effect at the same edge:
  - mtc0 updates IM and IE.
  - The exception update wins for EXL, ExcCode and EPC.
- mtc0 Status and ERET at the same edge: the mtc0 value is applied, then EXL is forced to 0.
- mfc0 read with wr_cp0_we and a matching rd: returns wr_cp0_wdata, except reading Cause, which ignores the write.
- Unimplemented register numbers read 0.
- Exception while EXL = 1: still taken; EPC and ExcCode are overwritten (no nesting support).
- reset asserted in ENTER/RETURN: FSM returns to RUN next edge; no redirect is issued.

Decomposition:
- Shared package cp0_defs holds:
  - register numbers CP0_STATUS = 12, CP0_CAUSE = 13, CP0_EPC = 14;
  - ExcCode constants EXC_INT = 0, EXC_SYS = 8, EXC_RI = 10, EXC_OV = 12;
  - the FSM state encodings;
  - the Status/Cause bit positions.
- One sub-module, cp0_regfile: the Status/Cause/EPC storage, write-priority muxing and the bypassed mfc0 read port.
- The FSM and arbitration stay in cp0_exception_ctrl.

Test Plan:
- Syscall:
  - Stimulus: mem_exc = 1, exccode = 8, mem_pc = 0x3010.
  - Response: next cycle flush = 1, redirect_pc = 0x4180; EPC = 0x3010, ExcCode = 8, EXL = 1.
- Interrupt masking:
  - Stimulus: Status = 0x0401 via mtc0, then irq[0] = 1.
  - Response: after the IP latch, interrupt taken with ExcCode = 0.
  - Repeat with IE = 0 or EXL = 1: no flush.
- ERET bypass:
  - Stimulus: mtc0 EPC ← 0x3100 in Wr in the same cycle as ERET in Mem.
  - Response: redirect_pc = 0x3100, EXL = 0.
- Simultaneous events:
  - Stimulus: mem_exc = 1 and int_req = 1 together.
  - Response: the exception wins (ExcCode = 12); in ENTER a second mem_exc is ignored.
- mfc0 bypass:
  - Stimulus: id_cp0_rd = 12 while mtc0 Status ← 0xFC01.
  - Response: rdata = 0xFC01.
  - mfc0 of rd = 5 returns 0.
- Reset mid-sequence:
  - Stimulus: reset asserted during ENTER.
  - Response: next cycle RUN; all registers 0; no redirect.
